// File: rtl/e_mdu_param.sv
// E-stage multiply/divide unit: parametrised width and latencies, multiply-accumulate,
// divide-by-zero leaves HI/LO untouched, D-stage-aware stall request.
module e_mdu_param #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [3:0]       md_sel,
  input  logic             d_md_use,
  output logic             md_stall,
  output logic             busy,
  output logic [WIDTH-1:0] md_out
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1,  OP_MULTU = 4'd2,  OP_DIV   = 4'd3,  OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5,  OP_MFLO  = 4'd6,  OP_MTHI  = 4'd7,  OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9,  OP_MADDU = 4'd10, OP_MSUB  = 4'd11, OP_MSUBU = 4'd12;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo, pend_hi, pend_lo;

  logic is_mul, is_div, sgn_mul, start, wr;
  logic [2*WIDTH-1:0] prod_s, prod_u, prod, acc, mul_res;
  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   abs_a, abs_b, div_b, uq, ur, q, r;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign is_mul  = (md_sel == OP_MULT) || (md_sel == OP_MULTU) || (md_sel == OP_MADD) ||
                   (md_sel == OP_MADDU) || (md_sel == OP_MSUB) || (md_sel == OP_MSUBU);
  assign is_div  = (md_sel == OP_DIV) || (md_sel == OP_DIVU);
  assign sgn_mul = (md_sel == OP_MULT) || (md_sel == OP_MADD) || (md_sel == OP_MSUB);
  assign start   = (is_mul || is_div) && !busy && !req;
  assign wr      = ((md_sel == OP_MTHI) || (md_sel == OP_MTLO)) && !busy && !req;

  // Sign-extended 2W x 2W product keeps the low 2W bits equal to the signed product
  assign prod_s = {{WIDTH{d1[WIDTH-1]}}, d1} * {{WIDTH{d2[WIDTH-1]}}, d2};
  assign prod_u = {{WIDTH{1'b0}}, d1} * {{WIDTH{1'b0}}, d2};
  assign prod   = sgn_mul ? prod_s : prod_u;
  assign acc    = {hi, lo};

  // Magnitude divide then fix signs; -2^(W-1)/-1 falls out as -2^(W-1) rem 0
  assign neg_a = (md_sel == OP_DIV) && d1[WIDTH-1];
  assign neg_b = (md_sel == OP_DIV) && d2[WIDTH-1];
  assign abs_a = neg_a ? -d1 : d1;
  assign abs_b = neg_b ? -d2 : d2;
  assign div_b = (d2 == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : abs_b;
  assign uq    = abs_a / div_b;
  assign ur    = abs_a % div_b;
  assign q     = (neg_a ^ neg_b) ? -uq : uq;
  assign r     = neg_a ? -ur : ur;

  always_comb begin
    mul_res = prod;
    if ((md_sel == OP_MADD) || (md_sel == OP_MADDU))      mul_res = acc + prod;
    else if ((md_sel == OP_MSUB) || (md_sel == OP_MSUBU)) mul_res = acc - prod;
    res_hi = mul_res[2*WIDTH-1:WIDTH];
    res_lo = mul_res[WIDTH-1:0];
    if (is_div) begin
      if (d2 == '0) begin
        res_hi = hi;
        res_lo = lo;
      end else begin
        res_hi = r;
        res_lo = q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            busy    <= 1'b1;
            cnt     <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            pend_hi <= res_hi;
            pend_lo <= res_lo;
          end else if (wr) begin
            if (md_sel == OP_MTHI) hi <= d1;
            else                   lo <= d1;
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            hi    <= pend_hi;
            lo    <= pend_lo;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign md_stall = d_md_use && (start || busy);

  always_comb begin
    md_out = '0;
    if (md_sel == OP_MFHI)      md_out = hi;
    else if (md_sel == OP_MFLO) md_out = lo;
  end
endmodule
